// File: rtl/universal_shift_reg_pkg.sv
// Shared definitions for the universal shift register: command encodings,
// FSM state type and a small decode helper.
package universal_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_SHLN = 3'd6;
  localparam logic [2:0] MODE_SHRN = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_multi(input logic [2:0] mode);
    return (mode == MODE_SHLN) || (mode == MODE_SHRN);
  endfunction

endpackage

// File: rtl/universal_shift_reg_shift_unit.sv
// Combinational one-step shifter: next register value and next serial-out bit
// for a given command. Non-shifting commands pass q and sout through.
module universal_shift_reg_shift_unit #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_sout,
  input  logic [2:0]       i_mode,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout
);
  import universal_shift_reg_pkg::*;

  always_comb begin
    o_q    = i_q;
    o_sout = i_sout;
    case (i_mode)
      MODE_SHL: begin
        o_q    = {i_q[WIDTH-2:0], i_sin};
        o_sout = i_q[WIDTH-1];
      end
      MODE_SHR: begin
        o_q    = {i_sin, i_q[WIDTH-1:1]};
        o_sout = i_q[0];
      end
      MODE_ROL: begin
        o_q    = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_sout = i_q[WIDTH-1];
      end
      MODE_ROR: begin
        o_q    = {i_q[0], i_q[WIDTH-1:1]};
        o_sout = i_q[0];
      end
      MODE_SHLN: begin
        o_q    = {i_q[WIDTH-2:0], 1'b0};
        o_sout = i_q[WIDTH-1];
      end
      MODE_SHRN: begin
        o_q    = {1'b0, i_q[WIDTH-1:1]};
        o_sout = i_q[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with load, single-bit shift/rotate and multi-cycle shift-by-N.
// state | meaning:  ST_IDLE | accepts commands ;  ST_SHIFT | SHLN/SHRN in progress
module universal_shift_reg #(
  parameter  int WIDTH = 7,
  localparam int SW    = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin,
  input  logic [SW-1:0]    i_shamt,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout,
  output logic             o_busy,
  output logic             o_done
);
  import universal_shift_reg_pkg::*;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_sh;
  logic             r_sout, w_sout_sh;
  logic             r_done;
  logic             r_dir;
  logic [SW-1:0]    r_cnt, w_n;
  logic [2:0]       w_op;
  logic             w_accept, w_multi;

  assign w_n      = (i_shamt > SW'(WIDTH)) ? SW'(WIDTH) : i_shamt;
  assign w_accept = (r_state == ST_IDLE) && i_en && (i_mode != MODE_HOLD);
  assign w_multi  = is_multi(i_mode);
  // While shifting, the latched direction replaces the (ignored) mode input.
  assign w_op     = (r_state == ST_SHIFT) ? (r_dir ? MODE_SHRN : MODE_SHLN) : i_mode;

  universal_shift_reg_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .i_q    (r_q),
    .i_sout (r_sout),
    .i_mode (w_op),
    .i_sin  (i_sin),
    .o_q    (w_q_sh),
    .o_sout (w_sout_sh)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && w_multi && (w_n > SW'(1))) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == SW'(1)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == ST_SHIFT);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_q    <= '0;
      r_sout <= 1'b0;
      r_done <= 1'b0;
      r_dir  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_SHIFT) begin
        r_q    <= w_q_sh;
        r_sout <= w_sout_sh;
        r_cnt  <= r_cnt - SW'(1);
        if (r_cnt == SW'(1)) r_done <= 1'b1;
      end else if (w_accept) begin
        if (i_mode == MODE_LOAD) begin
          r_q <= i_d;
        end else if (w_multi) begin
          r_dir <= (i_mode == MODE_SHRN);
          if (w_n != '0) begin
            r_q    <= w_q_sh;
            r_sout <= w_sout_sh;
          end
          // n of 0 or 1 completes on the acceptance edge.
          if (w_n <= SW'(1)) r_done <= 1'b1;
          else               r_cnt  <= w_n - SW'(1);
        end else begin
          r_q    <= w_q_sh;
          r_sout <= w_sout_sh;
        end
      end
    end
  end

  assign o_q    = r_q;
  assign o_sout = r_sout;
  assign o_done = r_done;

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised successor to the team's fixed 7-bit storage register: a WIDTH-bit register with parallel load, single-bit shifts and rotates with serial in/out, and a multi-cycle shift-by-N operation. It drops in wherever the plain register is used (mode HOLD/LOAD reproduces it) and also serves as the serialiser/deserialiser and barrel-shift substitute in datapaths that cannot afford a combinational shifter.

## Interface
- WIDTH, 7, register width in bits (≥2)
- SW, $clog2(WIDTH+1), width of shamt (derived, not overridden)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- en  input  1  command strobe; sampled only while idle
- mode  input  3  command: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 SHLN, 7 SHRN
- d  input  WIDTH  parallel load data
- sin  input  1  serial input bit for SHL/SHR
- shamt  input  SW  shift amount for SHLN/SHRN
- q  output  WIDTH  register contents
- sout  output  1  last bit shifted/rotated out (registered)
- busy  output  1  multi-cycle shift in progress
- done  output  1  one-cycle pulse: SHLN/SHRN complete

## Operation
- Reset (reset=0 at edge): q=0, sout=0, busy=0, done=0, FSM→IDLE, counter=0; overrides everything, including an in-flight SHLN/SHRN.
- FSM states IDLE, SHIFT. busy = (state==SHIFT).
- IDLE, en=0 or mode=HOLD: q holds; sout holds; done=0.
- LOAD: q←d; sout unchanged.
- SHL: q←{q[W-2:0],sin}, sout←q[W-1]. SHR: q←{sin,q[W-1:1]}, sout←q[0].
- ROL: q←{q[W-2:0],q[W-1]}, sout←q[W-1]. ROR: q←{q[0],q[W-1:1]}, sout←q[0]. sin ignored.
- SHLN/SHRN: logical shift, zero fill, one bit per cycle. Effective n = min(shamt, WIDTH).
  - n=0: q unchanged, stay IDLE, done=1 next cycle.
  - n=1: acceptance edge shifts once, stay IDLE, done=1.
  - n≥2: acceptance edge shifts once, counter←n-1, →SHIFT. Each SHIFT edge shifts once and decrements; edge with counter==1 →IDLE, done=1.
  - sout tracks each bit shifted out (last one retained).
- In SHIFT: en, mode, d, sin, shamt ignored (no queuing); caller waits for busy=0.
- done asserted only on the cycle after the final shift; cleared next edge.

## Timing
- Single-cycle commands: result on q one edge after en=1 sampled.
- SHLN/SHRN n≥1: q final after exactly n edges from acceptance; busy high for n-1 cycles; done high the cycle q becomes final.
- Back-to-back: a new command may be accepted on the same edge that done rises's following edge, i.e. whenever busy=0; done and a new acceptance may coincide (done of previous, new command sampled).
- No combinational path input→output.

## Structure
- Shared package: mode encoding constants (MODE_HOLD..MODE_SHRN), FSM state typedef (ST_IDLE, ST_SHIFT).
- One natural sub-module: shift_unit — combinational next-q/next-sout from (q, mode, sin); FSM and counter stay in the top.

## Test plan
- Reset then LOAD d=7'b0000111 → q=0000111 next edge; reset=0 mid-stream → q=0000000, sout=0 next edge.
- q=1000001, SHL sin=1 → q=0000011, sout=1; SHR sin=0 from 0000011 → q=0000001, sout=1.
- q=1000001, ROL → 0000011; ROR from 0000011 → 1000001, sout=1.
- q=1111111, SHLN shamt=3 → busy high 2 cycles, q=1111000 with done=1 after 3 edges; en/mode toggled during busy ignored.
- SHRN shamt=0 → q unchanged, done pulse, busy never high; SHRN shamt=7 on 1010101 → q=0000000 after 7 edges, sout=1.
- SHLN shamt=5, reset asserted after 2 edges → q=0, busy=0, done never pulses.
